// File: rtl/mmu_pkg.sv
// Shared defaults, FSM state encoding and lane-slice helper for the MMU feeder.
package mmu_pkg;

  localparam int MMU_N  = 4;
  localparam int MMU_DW = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_WT  = 3'd1,
    SHIFT_WT = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4
  } mmu_state_e;

  // LSB position of lane `lane` in a packed row of `dw`-bit elements.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/mmu_feeder_if.sv
// Operand-side valid/ready handshakes plus the MMU-facing drive bundle.
// slave = feeder side; master = operand buffers and MMU observer.
interface mmu_feeder_if
  import mmu_pkg::*;
#(
  parameter int N  = MMU_N,
  parameter int DW = MMU_DW
);
  logic            wt_valid;
  logic            wt_ready;
  logic [N*DW-1:0] wt_row;
  logic            dat_valid;
  logic            dat_ready;
  logic            dat_last;
  logic [N*DW-1:0] dat_row;
  logic            control;
  logic [N*DW-1:0] wt_arr;
  logic [N*DW-1:0] data_arr;
  logic            busy;
  logic            done;

  modport master (
    output wt_valid, wt_row, dat_valid, dat_last, dat_row,
    input  wt_ready, dat_ready, control, wt_arr, data_arr, busy, done
  );

  modport slave (
    input  wt_valid, wt_row, dat_valid, dat_last, dat_row,
    output wt_ready, dat_ready, control, wt_arr, data_arr, busy, done
  );
endinterface

// File: rtl/mmu_skew_line.sv
// Zero-reset DEPTH-stage delay line for one lane; DEPTH=0 is a plain wire.
// Latency DEPTH cycles, never stalls.
module mmu_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][DW-1:0] stage_q, stage_d;

    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/mmu_feeder.sv
// Buffers N weight rows, shifts them into the MMU (control=1, N cycles), then streams diagonally skewed activations.
// Registered outputs; lane j lags acceptance by j edges; ready is state-driven. MMU_FEEDER_BUBBLE_CNT_EN adds bubble_cnt.
module mmu_feeder
  import mmu_pkg::*;
#(
  parameter int N  = MMU_N,
  parameter int DW = MMU_DW
) (
  input  logic clk,
  input  logic rst_n,
  mmu_feeder_if.slave bus
`ifdef MMU_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2);

  mmu_state_e state_q, state_d;
  logic [CW-1:0] wt_cnt_q, wt_cnt_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic [N-1:0][N*DW-1:0] wt_buf_q, wt_buf_d;

  logic            control_q, control_d;
  logic [N*DW-1:0] wt_arr_q, wt_arr_d;
  logic [N*DW-1:0] data_arr_q, data_arr_d;
  logic            wt_ready_q, wt_ready_d;
  logic            dat_ready_q, dat_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            wt_hs, dat_hs;
  logic [N*DW-1:0] skew_in, skew_out;

  // Ready flops only rise in the states that accept, so these imply the state.
  assign wt_hs   = bus.wt_valid  & wt_ready_q;
  assign dat_hs  = bus.dat_valid & dat_ready_q;
  assign skew_in = dat_hs ? bus.dat_row : '0;

  for (genvar j = 0; j < N; j++) begin : g_lane
    mmu_skew_line #(.DEPTH(j), .DW(DW)) u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (skew_in[lane_lsb(j, DW) +: DW]),
      .dout (skew_out[lane_lsb(j, DW) +: DW])
    );
  end

  always_comb begin
    state_d     = state_q;
    wt_cnt_d    = wt_cnt_q;
    sh_cnt_d    = sh_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wt_buf_d    = wt_buf_q;
    if (wt_hs) wt_buf_d[wt_cnt_q] = bus.wt_row;

    case (state_q)
      IDLE, LOAD_WT: begin
        if (wt_hs) begin
          if (wt_cnt_q == LAST_IDX) begin
            state_d  = SHIFT_WT;
            wt_cnt_d = '0;
            sh_cnt_d = '0;
          end else begin
            state_d  = LOAD_WT;
            wt_cnt_d = wt_cnt_q + 1'b1;
          end
        end
      end
      SHIFT_WT: begin
        if (sh_cnt_q == LAST_IDX) begin
          state_d  = STREAM;
          sh_cnt_d = '0;
        end else begin
          sh_cnt_d = sh_cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (dat_hs && bus.dat_last) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = IDLE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs track the next state so they line up with the state register.
    control_d   = (state_d == SHIFT_WT);
    wt_arr_d    = control_d ? wt_buf_d[sh_cnt_d] : '0;
    data_arr_d  = skew_out;
    wt_ready_d  = (state_d == IDLE) || (state_d == LOAD_WT);
    dat_ready_d = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DRAIN) && (drain_cnt_d == DRAIN_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wt_cnt_q    <= '0;
      sh_cnt_q    <= '0;
      drain_cnt_q <= '0;
      wt_buf_q    <= '0;
      control_q   <= 1'b0;
      wt_arr_q    <= '0;
      data_arr_q  <= '0;
      wt_ready_q  <= 1'b0;
      dat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wt_cnt_q    <= wt_cnt_d;
      sh_cnt_q    <= sh_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wt_buf_q    <= wt_buf_d;
      control_q   <= control_d;
      wt_arr_q    <= wt_arr_d;
      data_arr_q  <= data_arr_d;
      wt_ready_q  <= wt_ready_d;
      dat_ready_q <= dat_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.control   = control_q;
  assign bus.wt_arr    = wt_arr_q;
  assign bus.data_arr  = data_arr_q;
  assign bus.wt_ready  = wt_ready_q;
  assign bus.dat_ready = dat_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef MMU_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (state_d == SHIFT_WT && state_q != SHIFT_WT)
      bubble_cnt_d = '0;
    else if (state_q == STREAM && !dat_hs && bubble_cnt_q != 16'hFFFF)
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Bench for mmu_feeder: directed jobs from the test plan plus random jobs against a cycle-indexed acceptance model.
module tb_mmu_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = N * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmu_feeder_if #(.N(N), .DW(DW)) bus();
`ifdef MMU_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  mmu_feeder #(.N(N), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef MMU_FEEDER_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Job description consumed by run_job.
  logic [WW-1:0] job_wt   [N];
  int            job_wgap [N];
  logic [WW-1:0] job_row  [16];
  int            job_dgap [16];
  int            job_nrows;
  bit            job_noise;
  int            job_abort;
  // Model state: row accepted at each edge of the current job.
  logic [WW-1:0] acc_row [512];
  bit            acc_vld [512];
  logic [WW-1:0] obs_seq [8];
  int            first_d;
  int            job_bubbles;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_control"},   WW'(bus.control),   '0);
    chk({tag, "_wt_arr"},    bus.wt_arr,         '0);
    chk({tag, "_data_arr"},  bus.data_arr,       '0);
    chk({tag, "_wt_ready"},  WW'(bus.wt_ready),  '0);
    chk({tag, "_dat_ready"}, WW'(bus.dat_ready), '0);
    chk({tag, "_busy"},      WW'(bus.busy),      '0);
    chk({tag, "_done"},      WW'(bus.done),      '0);
  endtask

  task automatic clear_job();
    for (int i = 0; i < N; i++) job_wgap[i] = 0;
    for (int i = 0; i < 16; i++) begin job_row[i] = '0; job_dgap[i] = 0; end
    job_noise = 1'b0;
    job_abort = -1;
  endtask

  // Drives one job cycle by cycle (inputs after a negedge, checks at the next negedge).
  task automatic run_job();
    int e = 0, nw = 0, nd = 0, wpos = -1, lpos = -1, wwait, dwait, nb = 0;
    bit finished = 1'b0, aborted = 1'b0, hs_w, hs_d, srdy, exp_ctrl;
    logic [WW-1:0] exp_d, exp_w;
    for (int i = 0; i < 512; i++) begin acc_vld[i] = 1'b0; acc_row[i] = '0; end
    for (int i = 0; i < 8; i++) obs_seq[i] = '0;
    first_d = -1;
    wwait = job_wgap[0];
    dwait = job_dgap[0];
    while (!finished && !aborted && e < 400) begin
      srdy = (wpos >= 0) && (e - 1 >= wpos + N) && (lpos < 0);
      hs_w = 1'b0; hs_d = 1'b0;
      bus.wt_valid = 1'b0; bus.wt_row = '0;
      bus.dat_valid = 1'b0; bus.dat_last = 1'b0; bus.dat_row = '0;
      if (nw < N) begin
        if (wwait > 0) wwait--;
        else begin bus.wt_valid = 1'b1; bus.wt_row = job_wt[nw]; hs_w = 1'b1; end
      end else if (job_noise && lpos < 0) begin
        bus.wt_valid = 1'b1; bus.wt_row = $urandom;
      end
      if (srdy) begin
        if (dwait > 0) dwait--;
        else begin
          bus.dat_valid = 1'b1; bus.dat_row = job_row[nd];
          bus.dat_last = (nd == job_nrows - 1); hs_d = 1'b1;
        end
      end else if (job_noise) begin
        bus.dat_valid = 1'b1; bus.dat_row = $urandom; bus.dat_last = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      if (hs_w) begin
        nw++;
        if (nw == N) wpos = e; else wwait = job_wgap[nw];
      end
      if (hs_d) begin
        acc_row[e] = bus.dat_row; acc_vld[e] = 1'b1;
        if (first_d < 0) first_d = e;
        nd++;
        if (bus.dat_last) lpos = e; else dwait = job_dgap[nd];
      end else if (srdy) nb++;
      @(negedge clk);
      exp_ctrl = (wpos >= 0) && (e >= wpos) && (e < wpos + N);
      exp_w = '0;
      if (exp_ctrl) exp_w = job_wt[e - wpos];
      exp_d = '0;
      for (int j = 0; j < N; j++)
        if (e - j >= 0 && acc_vld[e - j]) exp_d[j*DW +: DW] = acc_row[e - j][j*DW +: DW];
      chk("control",   WW'(bus.control),   WW'(exp_ctrl));
      chk("wt_arr",    bus.wt_arr,         exp_w);
      chk("wt_ready",  WW'(bus.wt_ready),  WW'((nw < N) || (lpos >= 0 && e >= lpos + N - 1)));
      chk("dat_ready", WW'(bus.dat_ready), WW'((wpos >= 0) && (e >= wpos + N) && (lpos < 0)));
      chk("data_arr",  bus.data_arr,       exp_d);
      chk("busy",      WW'(bus.busy),      WW'((nw > 0) && !(lpos >= 0 && e >= lpos + N - 1)));
      chk("done",      WW'(bus.done),      WW'((lpos >= 0) && (e == lpos + N - 2)));
      if (first_d >= 0 && e >= first_d && e - first_d < 8) obs_seq[e - first_d] = bus.data_arr;
      if (job_abort >= 0 && wpos >= 0 && e == wpos + N + job_abort) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        bus.wt_valid = 1'b0; bus.dat_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end
      if (lpos >= 0 && e >= lpos + N) finished = 1'b1;
      e++;
    end
    bus.wt_valid = 1'b0; bus.dat_valid = 1'b0; bus.dat_last = 1'b0;
    tests++;
    assert (finished || aborted) else begin
      fails++;
      $error("FAIL job_timeout: observed %0d cycles without completion, expected done", e);
    end
    job_bubbles = nb;
`ifdef MMU_FEEDER_BUBBLE_CNT_EN
    if (finished) chk("bubble_cnt", WW'(bubble_cnt), WW'(nb));
`endif
  endtask

  task automatic load_directed();
    clear_job();
    job_wt[0] = 32'h05020304; job_wt[1] = 32'h03010203;
    job_wt[2] = 32'h07040102; job_wt[3] = 32'h01020403;
    job_nrows = 4;
    job_row[0] = 32'h00010101; job_row[1] = 32'h02010202;
    job_row[2] = 32'h04030100; job_row[3] = 32'h05010200;
  endtask

  task automatic chk_stream_seq(input string tag);
    logic [WW-1:0] seq_exp [8];
    seq_exp = '{32'h00000001, 32'h00000102, 32'h00010200, 32'h00010100,
                32'h02030200, 32'h04010000, 32'h05000000, 32'h00000000};
    for (int i = 0; i < 8; i++) chk($sformatf("%s%0d", tag, i), obs_seq[i], seq_exp[i]);
  endtask

  initial begin
    logic [WW-1:0] one_exp [5];
    bus.wt_valid = 1'b0; bus.wt_row = '0;
    bus.dat_valid = 1'b0; bus.dat_last = 1'b0; bus.dat_row = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
`ifdef MMU_FEEDER_BUBBLE_CNT_EN
    chk("reset_bubble_cnt", WW'(bubble_cnt), '0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wt_ready", WW'(bus.wt_ready), WW'(1));

    // Back-to-back weights, continuous skewed stream.
    load_directed();
    run_job();
    chk_stream_seq("stream_seq");

    // Three-cycle wt_valid gap between rows 2 and 3.
    load_directed();
    job_wgap[3] = 3;
    run_job();
    chk_stream_seq("wgap_seq");

    // One-cycle dat_valid gap between rows 1 and 2.
    load_directed();
    job_dgap[2] = 1;
    run_job();
    chk("bubble_model_cnt", WW'(job_bubbles), WW'(1));

    // Ignored inputs while loading/shifting, single-row job.
    load_directed();
    job_noise = 1'b1;
    job_nrows = 1;
    job_row[0] = 32'h04030201;
    run_job();
    one_exp = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000, 32'h00000000};
    for (int i = 0; i < 5; i++) chk($sformatf("single_seq%0d", i), obs_seq[i], one_exp[i]);

    // Reset during STREAM cycle 2, then a fresh job.
    load_directed();
    job_abort = 2;
    run_job();
    @(negedge clk);
    chk("post_abort_wt_ready", WW'(bus.wt_ready), WW'(1));
    chk("post_abort_data_arr", bus.data_arr, '0);
    load_directed();
    run_job();
    chk_stream_seq("fresh_seq");

    // Random jobs.
    for (int k = 0; k < 14; k++) begin
      clear_job();
      for (int i = 0; i < N; i++) begin job_wt[i] = $urandom; job_wgap[i] = $urandom_range(0, 2); end
      job_nrows = $urandom_range(1, 8);
      for (int i = 0; i < 16; i++) begin job_row[i] = $urandom; job_dgap[i] = $urandom_range(0, 2); end
      job_noise = 1'($urandom_range(0, 1));
      run_job();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
